data_island_packet_scheduler: RTL and testbench

DATA_ISLAND_PACKET_SCHEDULER -- requirements
Module: data_island_packet_scheduler

---
 rtl/data_island_packet_scheduler.sv | 160 ++++++++++++++++
 tb/tb_data_island_packet_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_island_packet_scheduler.sv
// Data-island packet scheduler: arbitrates ACR, audio and three infoframes onto a
// single packet slot each time packet_enable opens one, with a bounded audio burst.
module data_island_packet_scheduler #(
    parameter int AUDIO_BURST_MAX = 4
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         packet_enable,
    input  logic         acr_req,
    input  logic [23:0]  acr_header,
    input  logic [223:0] acr_sub,
    input  logic         aud_req,
    input  logic [23:0]  aud_header,
    input  logic [223:0] aud_sub,
    input  logic [71:0]  if_header,
    input  logic [671:0] if_sub,
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic [2:0]   pkt_type,
    output logic         acr_ack,
    output logic         aud_ack,
    output logic [2:0]   if_sent,
    output logic         if_overrun
);

    typedef enum logic [2:0] {
        PKT_NULL = 3'd0,
        PKT_ACR  = 3'd1,
        PKT_AUD  = 3'd2,
        PKT_IF0  = 3'd3,
        PKT_IF1  = 3'd4,
        PKT_IF2  = 3'd5
    } pkt_t;

    localparam logic [3:0] BURST_MAX = 4'(AUDIO_BURST_MAX);

    logic       acr_pending;
    logic [2:0] if_pending;
    logic [3:0] aud_streak;
    logic [1:0] rr_last;

    logic         if_any_p0;
    logic [1:0]   if_idx_p0;
    pkt_t         sel_type_p0;
    logic [23:0]  sel_header_p0;
    logic [223:0] sel_sub_p0;
    logic         grant_acr_p0;
    logic         grant_aud_p0;
    logic         grant_if_p0;

    // First pending infoframe at or after (last+1) mod 3, wrapping around.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
        logic [1:0] start;
        logic [1:0] cand;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        start   = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            cand = start + 2'(k);
            if (cand > 2'd2) cand = cand - 2'd3;
            if (!found && pend[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    // Stage p0: arbitration on the pending state registered before this cycle
    assign if_any_p0 = |if_pending;
    assign if_idx_p0 = rr_pick(if_pending, rr_last);

    always_comb begin
        sel_type_p0   = PKT_NULL;
        sel_header_p0 = '0;
        sel_sub_p0    = '0;
        if (acr_pending) begin
            sel_type_p0   = PKT_ACR;
            sel_header_p0 = acr_header;
            sel_sub_p0    = acr_sub;
        end else if ((if_any_p0 && aud_streak == BURST_MAX) || (!aud_req && if_any_p0)) begin
            case (if_idx_p0)
                2'd0: begin
                    sel_type_p0   = PKT_IF0;
                    sel_header_p0 = if_header[23:0];
                    sel_sub_p0    = if_sub[223:0];
                end
                2'd1: begin
                    sel_type_p0   = PKT_IF1;
                    sel_header_p0 = if_header[47:24];
                    sel_sub_p0    = if_sub[447:224];
                end
                default: begin
                    sel_type_p0   = PKT_IF2;
                    sel_header_p0 = if_header[71:48];
                    sel_sub_p0    = if_sub[671:448];
                end
            endcase
        end else if (aud_req) begin
            sel_type_p0   = PKT_AUD;
            sel_header_p0 = aud_header;
            sel_sub_p0    = aud_sub;
        end
    end

    assign grant_acr_p0 = packet_enable && (sel_type_p0 == PKT_ACR);
    assign grant_aud_p0 = packet_enable && (sel_type_p0 == PKT_AUD);
    assign grant_if_p0  = packet_enable && (sel_type_p0 >= PKT_IF0);

    // Stage p1: registered packet outputs and pending/arbitration state
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            header      <= '0;
            sub         <= '0;
            pkt_type    <= '0;
            acr_ack     <= 1'b0;
            aud_ack     <= 1'b0;
            if_sent     <= '0;
            if_overrun  <= 1'b0;
            acr_pending <= 1'b0;
            if_pending  <= '0;
            aud_streak  <= '0;
            rr_last     <= 2'd2;
        end else begin
            acr_ack    <= grant_acr_p0;
            aud_ack    <= grant_aud_p0;
            if_sent    <= grant_if_p0 ? (3'b001 << if_idx_p0) : 3'b000;
            if_overrun <= frame_start && if_any_p0;

            // A new request on the grant cycle wins over the clear.
            if (acr_req)
                acr_pending <= 1'b1;
            else if (grant_acr_p0)
                acr_pending <= 1'b0;

            if (frame_start)
                if_pending <= 3'b111;
            else if (grant_if_p0)
                if_pending <= if_pending & ~(3'b001 << if_idx_p0);

            if (!if_any_p0)
                aud_streak <= '0;
            else if (grant_aud_p0)
                aud_streak <= (aud_streak < BURST_MAX) ? aud_streak + 4'd1 : aud_streak;
            else if (packet_enable)
                aud_streak <= '0;

            if (grant_if_p0)
                rr_last <= if_idx_p0;

            if (packet_enable) begin
                header   <= sel_header_p0;
                sub      <= sel_sub_p0;
                pkt_type <= sel_type_p0;
            end
        end
    end

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Directed bench for data_island_packet_scheduler: vector table plus hand sequences
// for reset, input-hold and round-robin-after-reset behaviour.
module tb_data_island_packet_scheduler;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         frame_start;
    logic         packet_enable;
    logic         acr_req;
    logic [23:0]  acr_header;
    logic [223:0] acr_sub;
    logic         aud_req;
    logic [23:0]  aud_header;
    logic [223:0] aud_sub;
    logic [71:0]  if_header;
    logic [671:0] if_sub;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [2:0]   pkt_type;
    logic         acr_ack;
    logic         aud_ack;
    logic [2:0]   if_sent;
    logic         if_overrun;

    localparam logic [23:0]  ACR_H = 24'h1A2B3C;
    localparam logic [23:0]  AUD_H = 24'h4D5E6F;
    localparam logic [23:0]  IF0_H = 24'h810101;
    localparam logic [23:0]  IF1_H = 24'h820202;
    localparam logic [23:0]  IF2_H = 24'h830303;
    localparam logic [223:0] ACR_S = {8{28'hACACACA}};
    localparam logic [223:0] AUD_S = {8{28'h5A5A5A5}};
    localparam logic [223:0] IF0_S = {8{28'h1111111}};
    localparam logic [223:0] IF1_S = {8{28'h2222222}};
    localparam logic [223:0] IF2_S = {8{28'h3333333}};

    int total = 0;
    int bad   = 0;

    data_island_packet_scheduler #(.AUDIO_BURST_MAX(4)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .frame_start  (frame_start),
        .packet_enable(packet_enable),
        .acr_req      (acr_req),
        .acr_header   (acr_header),
        .acr_sub      (acr_sub),
        .aud_req      (aud_req),
        .aud_header   (aud_header),
        .aud_sub      (aud_sub),
        .if_header    (if_header),
        .if_sub       (if_sub),
        .header       (header),
        .sub          (sub),
        .pkt_type     (pkt_type),
        .acr_ack      (acr_ack),
        .aud_ack      (aud_ack),
        .if_sent      (if_sent),
        .if_overrun   (if_overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic       fs;
        logic       pe;
        logic       ar;
        logic       au;
        logic [2:0] typ;
        logic       aa;
        logic       ua;
        logic [2:0] ifs;
        logic       ov;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(logic fs, logic pe, logic ar, logic au, logic [2:0] typ,
                                logic aa, logic ua, logic [2:0] ifs, logic ov);
        vec_t v;
        v.fs = fs; v.pe = pe; v.ar = ar; v.au = au;
        v.typ = typ; v.aa = aa; v.ua = ua; v.ifs = ifs; v.ov = ov;
        return v;
    endfunction

    function automatic logic [23:0] exp_hdr(logic [2:0] t);
        case (t)
            3'd1:    return ACR_H;
            3'd2:    return AUD_H;
            3'd3:    return IF0_H;
            3'd4:    return IF1_H;
            3'd5:    return IF2_H;
            default: return 24'h0;
        endcase
    endfunction

    function automatic logic [223:0] exp_sub(logic [2:0] t);
        case (t)
            3'd1:    return ACR_S;
            3'd2:    return AUD_S;
            3'd3:    return IF0_S;
            3'd4:    return IF1_S;
            3'd5:    return IF2_S;
            default: return 224'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic pe, input logic ar, input logic au);
        @(negedge clk_pixel);
        frame_start   = fs;
        packet_enable = pe;
        acr_req       = ar;
        aud_req       = au;
        @(posedge clk_pixel);
        #1;
    endtask

    initial begin
        //              fs pe ar au typ aa ua ifs     ov
        vecs[0]  = mk(0, 1, 0, 0, 3'd0, 0, 0, 3'b000, 0);
        vecs[1]  = mk(0, 0, 1, 1, 3'd0, 0, 0, 3'b000, 0);
        vecs[2]  = mk(0, 1, 0, 1, 3'd1, 1, 0, 3'b000, 0);
        vecs[3]  = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[4]  = mk(1, 0, 0, 0, 3'd2, 0, 0, 3'b000, 0);
        vecs[5]  = mk(0, 1, 0, 0, 3'd3, 0, 0, 3'b001, 0);
        vecs[6]  = mk(0, 1, 0, 0, 3'd4, 0, 0, 3'b010, 0);
        vecs[7]  = mk(0, 1, 0, 0, 3'd5, 0, 0, 3'b100, 0);
        vecs[8]  = mk(0, 0, 0, 0, 3'd5, 0, 0, 3'b000, 0);
        vecs[9]  = mk(1, 0, 0, 1, 3'd5, 0, 0, 3'b000, 0);
        vecs[10] = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[11] = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[12] = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[13] = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[14] = mk(0, 1, 0, 1, 3'd3, 0, 0, 3'b001, 0);
        vecs[15] = mk(0, 1, 0, 1, 3'd2, 0, 1, 3'b000, 0);
        vecs[16] = mk(1, 0, 0, 0, 3'd2, 0, 0, 3'b000, 1);
        vecs[17] = mk(0, 1, 0, 0, 3'd4, 0, 0, 3'b010, 0);
        vecs[18] = mk(0, 0, 1, 0, 3'd4, 0, 0, 3'b000, 0);
        vecs[19] = mk(0, 1, 1, 0, 3'd1, 1, 0, 3'b000, 0);
        vecs[20] = mk(0, 1, 0, 0, 3'd1, 1, 0, 3'b000, 0);
        vecs[21] = mk(0, 1, 0, 0, 3'd5, 0, 0, 3'b100, 0);
        vecs[22] = mk(0, 1, 0, 0, 3'd3, 0, 0, 3'b001, 0);
        vecs[23] = mk(0, 1, 0, 0, 3'd0, 0, 0, 3'b000, 0);
        vecs[24] = mk(1, 0, 0, 0, 3'd0, 0, 0, 3'b000, 0);
        vecs[25] = mk(1, 1, 0, 0, 3'd4, 0, 0, 3'b010, 1);
        vecs[26] = mk(0, 1, 0, 0, 3'd5, 0, 0, 3'b100, 0);
        vecs[27] = mk(0, 1, 0, 0, 3'd3, 0, 0, 3'b001, 0);
        vecs[28] = mk(0, 1, 0, 0, 3'd4, 0, 0, 3'b010, 0);
        vecs[29] = mk(0, 1, 0, 0, 3'd0, 0, 0, 3'b000, 0);

        acr_header = ACR_H;
        acr_sub    = ACR_S;
        aud_header = AUD_H;
        aud_sub    = AUD_S;
        if_header  = {IF2_H, IF1_H, IF0_H};
        if_sub     = {IF2_S, IF1_S, IF0_S};

        // Reset with busy inputs that must be ignored
        reset = 1'b1;
        frame_start = 1'b1; packet_enable = 1'b1; acr_req = 1'b1; aud_req = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1;
        check("reset pkt_type", 224'(pkt_type), 224'd0);
        check("reset header", 224'(header), 224'd0);
        check("reset sub", sub, 224'd0);
        check("reset flags", 224'({acr_ack, aud_ack, if_sent, if_overrun}), 224'd0);

        @(negedge clk_pixel);
        reset = 1'b0;
        frame_start = 1'b0; packet_enable = 1'b0; acr_req = 1'b0; aud_req = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].fs, vecs[i].pe, vecs[i].ar, vecs[i].au);
            check($sformatf("row%0d pkt_type", i), 224'(pkt_type), 224'(vecs[i].typ));
            check($sformatf("row%0d flags", i),
                  224'({acr_ack, aud_ack, if_sent, if_overrun}),
                  224'({vecs[i].aa, vecs[i].ua, vecs[i].ifs, vecs[i].ov}));
            check($sformatf("row%0d header", i), 224'(header), 224'(exp_hdr(vecs[i].typ)));
            check($sformatf("row%0d sub", i), sub, exp_sub(vecs[i].typ));
        end

        // Held outputs must not follow requester data changing after the grant
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        check("hold grant type", 224'(pkt_type), 224'd1);
        @(negedge clk_pixel);
        acr_header = 24'hFFFFFF;
        acr_sub    = {224{1'b1}};
        packet_enable = 1'b0;
        @(posedge clk_pixel);
        #1;
        check("hold header", 224'(header), 224'(ACR_H));
        check("hold sub", sub, ACR_S);
        check("hold ack cleared", 224'(acr_ack), 224'd0);
        @(negedge clk_pixel);
        acr_header = ACR_H;
        acr_sub    = ACR_S;

        // Mid-operation reset discards pending ACR and infoframes
        drive(1, 0, 1, 0);
        @(negedge clk_pixel);
        reset = 1'b1;
        frame_start = 1'b0; packet_enable = 1'b0; acr_req = 1'b0; aud_req = 1'b0;
        @(posedge clk_pixel);
        #1;
        check("midreset pkt_type", 224'(pkt_type), 224'd0);
        check("midreset header", 224'(header), 224'd0);
        @(negedge clk_pixel);
        reset = 1'b0;
        drive(0, 1, 0, 0);
        check("post-reset null type", 224'(pkt_type), 224'd0);
        check("post-reset flags", 224'({acr_ack, aud_ack, if_sent, if_overrun}), 224'd0);

        // Round-robin pointer restarts so infoframe 0 goes first
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        check("post-reset rr type", 224'(pkt_type), 224'd3);
        check("post-reset rr if_sent", 224'(if_sent), 224'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
